// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single shared memory port.
// One transaction is outstanding at a time. The request is accepted in IDLE,
// issued to memory, and the memory response is captured. The captured data is
// then returned to the requester that owns the transaction.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 (page-table walker)
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [ADDR_W-1:0] req0_addr_i,
  output logic              resp0_valid_o,
  input  logic              resp0_ready_i,
  output logic [DATA_W-1:0] resp0_data_o,
  // requester 1 (data port)
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  output logic              resp1_valid_o,
  input  logic              resp1_ready_i,
  output logic [DATA_W-1:0] resp1_data_o,
  // shared memory
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_resp_valid_i,
  output logic              mem_resp_ready_o,
  input  logic [DATA_W-1:0] mem_data_i,
  // status
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MREQ  = 2'd1,
    ST_MRESP = 2'd2,
    ST_CRESP = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_prio;
  logic              r_owner;
  logic              r_busy;
  logic              r_mem_req_valid;
  logic              r_mem_resp_ready;
  logic              r_resp0_valid;
  logic              r_resp1_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_idle;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_resp_hs;
  logic              w_resp0_valid;
  logic              w_resp1_valid;

  // Grant decision: a lone requester wins; on a tie the priority pointer decides.
  // Gating with rst keeps every ready low during the reset cycle itself.
  assign w_idle   = (r_state == ST_IDLE) && !rst;
  assign w_grant0 = w_idle && req0_valid_i && (!req1_valid_i || !r_prio);
  assign w_grant1 = w_idle && req1_valid_i && (!req0_valid_i ||  r_prio);

  // Only the owner's response valid is ever set, so an OR covers both requesters.
  assign w_resp_hs = (r_resp0_valid && resp0_ready_i) ||
                     (r_resp1_valid && resp1_ready_i);

  // Main control FSM. The state-driven outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_prio           <= 1'b0;
      r_owner          <= 1'b0;
      r_busy           <= 1'b0;
      r_mem_req_valid  <= 1'b0;
      r_mem_resp_ready <= 1'b0;
      r_resp0_valid    <= 1'b0;
      r_resp1_valid    <= 1'b0;
      r_addr           <= '0;
      r_data           <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_state         <= ST_MREQ;
            r_owner         <= w_grant1;
            r_addr          <= w_grant1 ? req1_addr_i : req0_addr_i;
            r_busy          <= 1'b1;
            r_mem_req_valid <= 1'b1;
          end
        end
        ST_MREQ: begin
          // The address stays in r_addr until the next acceptance.
          if (mem_req_ready_i) begin
            r_state          <= ST_MRESP;
            r_mem_req_valid  <= 1'b0;
            r_mem_resp_ready <= 1'b1;
          end
        end
        ST_MRESP: begin
          if (mem_resp_valid_i) begin
            r_state          <= ST_CRESP;
            r_data           <= mem_data_i;
            r_mem_resp_ready <= 1'b0;
            r_resp0_valid    <= !r_owner;
            r_resp1_valid    <=  r_owner;
          end
        end
        ST_CRESP: begin
          // After completion the next grant goes to the other requester.
          // No acceptance happens in this cycle.
          if (w_resp_hs) begin
            r_state       <= ST_IDLE;
            r_prio        <= ~r_owner;
            r_busy        <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode. The rst gating forces the outputs to idle in the reset cycle.
  assign w_resp0_valid    = r_resp0_valid && !rst;
  assign w_resp1_valid    = r_resp1_valid && !rst;

  assign req0_ready_o     = w_grant0;
  assign req1_ready_o     = w_grant1;
  assign resp0_valid_o    = w_resp0_valid;
  assign resp1_valid_o    = w_resp1_valid;
  assign resp0_data_o     = w_resp0_valid ? r_data : '0;
  assign resp1_data_o     = w_resp1_valid ? r_data : '0;
  assign mem_req_valid_o  = r_mem_req_valid && !rst;
  assign mem_resp_ready_o = r_mem_resp_ready && !rst;
  assign mem_addr_o       = r_addr;
  assign busy_o           = r_busy && !rst;
  assign owner_o          = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter. A small memory
// model returns read data two edges after the request handshake.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [31:0] req0_addr_i = '0, req1_addr_i = '0;
  logic        req0_ready_o, req1_ready_o;
  logic        resp0_valid_o, resp1_valid_o;
  logic        resp0_ready_i = 1'b0, resp1_ready_i = 1'b0;
  logic [31:0] resp0_data_o, resp1_data_o;
  logic        mem_req_valid_o, mem_resp_ready_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_data_i;
  logic        busy_o, owner_o;

  int checks = 0;
  int failures = 0;
  int txn_id = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_addr_i(req0_addr_i),
    .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i), .resp0_data_o(resp0_data_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_addr_i(req1_addr_i),
    .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i), .resp1_data_o(resp1_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  // Memory contents: fixed words at the addresses the test uses by name, and a swizzle elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0000_0400: mem_fn = 32'h0000_0801;
      32'h0000_0800: mem_fn = 32'h1000_000F;
      32'h0000_0804: mem_fn = 32'h1100_000F;
      default:       mem_fn = {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  // Memory model: the request handshake loads a pipeline stage. The response becomes valid one edge later.
  logic        m_p1 = 1'b0, m_v = 1'b0;
  logic [31:0] m_d = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_p1 <= 1'b0;
      m_v  <= 1'b0;
    end else begin
      if (mem_req_valid_o && mem_req_ready_i) begin
        m_p1 <= 1'b1;
        m_d  <= mem_fn(mem_addr_o);
      end else begin
        m_p1 <= 1'b0;
      end
      if (m_p1) m_v <= 1'b1;
      else if (m_v && mem_resp_ready_o) m_v <= 1'b0;
    end
  end
  assign mem_resp_valid_i = m_v;
  assign mem_data_i       = m_v ? m_d : 32'hDEAD_BEEF;

  typedef struct {
    bit          do_rst;
    bit          v0;
    logic [31:0] a0;
    bit          v1;
    logic [31:0] a1;
    bit          hold;
    bit          exp_owner;
    logic [31:0] exp_data;
    int          mstall;
    int          rstall;
    int          exp_lat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Assert rst with both valids high, then check that every output is idle.
  task automatic do_reset();
    rst = 1'b1;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    #1;
    chk("rst_ready", {req0_ready_o, req1_ready_o}, 0);
    chk("rst_resp_valid", {resp0_valid_o, resp1_valid_o}, 0);
    chk("rst_mem_valid", {mem_req_valid_o, mem_resp_ready_o}, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_owner", owner_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", resp0_data_o | resp1_data_o, 0);
    rst = 1'b0;
  endtask

  // Run one complete transaction and check it cycle by cycle.
  task automatic run_txn(input vec_t v, input bit glitch);
    int          lat, mem_hs, mleft, rleft;
    bit          ok, ov, rdy;
    logic [31:0] eaddr;
    eaddr         = v.exp_owner ? v.a1 : v.a0;
    req0_valid_i  = v.v0;
    req0_addr_i   = v.a0;
    req1_valid_i  = v.v1;
    req1_addr_i   = v.a1;
    resp0_ready_i = v.exp_owner;
    resp1_ready_i = !v.exp_owner;
    mleft = v.mstall;
    rleft = v.rstall;
    mem_req_ready_i = (mleft == 0);
    lat = 0;
    mem_hs = 0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req0_ready_o || req1_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_seen", ok, 1);
    if (!ok) return;
    chk("grant0", req0_ready_o, !v.exp_owner);
    chk("grant1", req1_ready_o, v.exp_owner);
    @(posedge clk);
    #1;
    if (!v.hold) begin
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
    end
    chk("owner", owner_o, v.exp_owner);
    ok = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (glitch && n == 1) begin req1_valid_i = 1'b1; req1_addr_i = 32'h800; end
      if (glitch && n == 2) req1_valid_i = 1'b0;
      mem_req_ready_i = (mleft == 0);
      if (mem_req_valid_o && mleft > 0) mleft--;
      ov = v.exp_owner ? resp1_valid_o : resp0_valid_o;
      if (ov) begin
        rdy = (rleft == 0);
        if (rleft > 0) rleft--;
      end else begin
        rdy = 1'b0;
      end
      if (v.exp_owner) resp1_ready_i = rdy;
      else resp0_ready_i = rdy;
      #1;
      chk("req_ready_busy", {req0_ready_o, req1_ready_o}, 0);
      chk("busy", busy_o, 1);
      chk("nonowner_resp_valid", v.exp_owner ? resp0_valid_o : resp1_valid_o, 0);
      chk("mem_addr_hold", mem_addr_o, eaddr);
      if (ov) chk("resp_data", v.exp_owner ? resp1_data_o : resp0_data_o, v.exp_data);
      if (!resp0_valid_o) chk("resp0_data_zero", resp0_data_o, 0);
      if (!resp1_valid_o) chk("resp1_data_zero", resp1_data_o, 0);
      if (mem_req_valid_o && mem_req_ready_i) mem_hs++;
      if (ov && rdy) begin
        lat = n;
        ok = 1'b1;
        break;
      end
    end
    chk("resp_handshake", ok, 1);
    if (!ok) return;
    chk("latency", lat, v.exp_lat);
    chk("mem_req_hs_count", mem_hs, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("busy_after", busy_o, 0);
    chk("resp_valid_after", {resp0_valid_o, resp1_valid_o}, 0);
    $display("txn %0d owner=%0d addr=0x%08h data=0x%08h lat=%0d",
             txn_id, owner_o, mem_addr_o, v.exp_data, lat);
    txn_id++;
  endtask

  vec_t hv;
  bit   found;

  initial begin
    //          rst  v0  a0      v1  a1      hold own data           ms rs lat
    tbl[0] = '{1'b1, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0801, 0, 0, 4};
    tbl[1] = '{1'b1, 1'b1, 32'h400, 1'b1, 32'h800, 1'b1, 1'b0, 32'h0000_0801, 0, 0, 4};
    tbl[2] = '{1'b0, 1'b1, 32'h400, 1'b1, 32'h800, 1'b1, 1'b1, 32'h1000_000F, 0, 0, 4};
    tbl[3] = '{1'b0, 1'b1, 32'h010, 1'b1, 32'h020, 1'b1, 1'b0, 32'hA5B5_5A5A, 0, 0, 4};
    tbl[4] = '{1'b0, 1'b1, 32'h010, 1'b1, 32'h020, 1'b1, 1'b1, 32'hA585_5A5A, 0, 0, 4};
    tbl[5] = '{1'b0, 1'b1, 32'h010, 1'b1, 32'h020, 1'b1, 1'b0, 32'hA5B5_5A5A, 0, 0, 4};
    tbl[6] = '{1'b0, 1'b1, 32'h010, 1'b1, 32'h020, 1'b1, 1'b1, 32'hA585_5A5A, 0, 0, 4};
    tbl[7] = '{1'b0, 1'b1, 32'h010, 1'b1, 32'h020, 1'b1, 1'b0, 32'hA5B5_5A5A, 0, 0, 4};
    tbl[8] = '{1'b0, 1'b1, 32'h010, 1'b1, 32'h020, 1'b0, 1'b1, 32'hA585_5A5A, 0, 0, 4};
    tbl[9] = '{1'b0, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0801, 5, 3, 12};

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_rst) do_reset();
      run_txn(tbl[i], 1'b0);
    end

    // req1 pulses valid while busy and must not be granted afterwards
    hv = '{1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0801, 0, 0, 4};
    run_txn(hv, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("idle_ready", {req0_ready_o, req1_ready_o}, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_mem_valid", mem_req_valid_o, 0);
    end

    // reset while waiting for the memory response
    req1_valid_i    = 1'b1;
    req1_addr_i     = 32'h800;
    mem_req_ready_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req1_ready_o) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("midrst_accept", found, 1);
    @(posedge clk);
    #1;
    req1_valid_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (mem_resp_ready_o) begin found = 1'b1; break; end
    end
    chk("midrst_in_mresp", found, 1);
    chk("midrst_owner_before", owner_o, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy_now", busy_o, 0);
    chk("midrst_resp_ready_now", mem_resp_ready_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_owner_after", owner_o, 0);
    for (int k = 0; k < 4; k++) begin
      chk("midrst_busy", busy_o, 0);
      chk("midrst_resp_valid", {resp0_valid_o, resp1_valid_o}, 0);
      chk("midrst_mem", {mem_req_valid_o, mem_resp_ready_o}, 0);
      @(negedge clk);
      #1;
    end
    hv = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h804, 1'b0, 1'b1, 32'h1100_000F, 0, 0, 4};
    run_txn(hv, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
